// File: rtl/ew_tex_qspi_fetch.sv
// Quad-output SPI flash fetch sequencer: 0x6B command + 24-bit address on io[0], dummy cycles,
// then DATA_NIBBLES nibbles read on io[3:0]. Every pin and handshake output is a flop.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | /CS high, o_ready=1, waiting for i_req
//   ST_CMD   | shifting the 8-bit read opcode out on io[0], MSB first
//   ST_ADDR  | shifting the 24-bit byte address out on io[0], MSB first
//   ST_DUMMY | io[0] released, clocking the dummy cycles
//   ST_DATA  | sampling one nibble of i_tex_in per SCLK period
//   ST_GAP   | /CS held high for the minimum deselect time
module ew_tex_qspi_fetch #(
    parameter logic [7:0] CMD             = 8'h6B,
    parameter int         DUMMY_CYCLES    = 8,
    parameter int         DATA_NIBBLES    = 2,
    parameter int         CSB_HIGH_CYCLES = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req,
    input  logic [23:0]               i_addr,
    output logic                      o_ready,
    output logic                      o_busy,
    output logic [4*DATA_NIBBLES-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_tex_csb,
    output logic                      o_tex_sclk,
    output logic                      o_tex_oeb0,
    output logic                      o_tex_out0,
    input  logic [3:0]                i_tex_in
);

    localparam int DW    = 4 * DATA_NIBBLES;
    localparam int MAX_A = (DUMMY_CYCLES > 23) ? DUMMY_CYCLES : 23;
    localparam int MAX_B = (DATA_NIBBLES > MAX_A) ? DATA_NIBBLES : MAX_A;
    localparam int MAX_C = (CSB_HIGH_CYCLES > MAX_B) ? CSB_HIGH_CYCLES : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [30:0]     sh, sh_n;
    logic [DW-1:0]   dsh, dsh_n;
    logic            pend, pend_n;
    logic            csb_n, sclk_n, oeb0_n, out0_n, ready_n, valid_n;
    logic [DW-1:0]   data_n;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sh         <= '0;
            dsh        <= '0;
            pend       <= 1'b0;
            o_tex_csb  <= 1'b1;
            o_tex_sclk <= 1'b0;
            o_tex_oeb0 <= 1'b1;
            o_tex_out0 <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_ready    <= 1'b1;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            dsh        <= dsh_n;
            pend       <= pend_n;
            o_tex_csb  <= csb_n;
            o_tex_sclk <= sclk_n;
            o_tex_oeb0 <= oeb0_n;
            o_tex_out0 <= out0_n;
            o_valid    <= valid_n;
            o_data     <= data_n;
            o_ready    <= ready_n;
            o_busy     <= !ready_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        dsh_n   = dsh;
        pend_n  = 1'b0;
        csb_n   = o_tex_csb;
        sclk_n  = o_tex_sclk;
        oeb0_n  = o_tex_oeb0;
        out0_n  = o_tex_out0;
        ready_n = o_ready;
        // The word is published one edge after /CS rises, inside the gap.
        valid_n = pend;
        data_n  = pend ? dsh : o_data;

        case (state)
            ST_IDLE: begin
                if (i_req && o_ready) begin
                    state_n = ST_CMD;
                    cnt_n   = CW'(7);
                    sh_n    = {CMD[6:0], i_addr};
                    csb_n   = 1'b0;
                    sclk_n  = 1'b0;
                    oeb0_n  = 1'b0;
                    out0_n  = CMD[7];
                    ready_n = 1'b0;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                if (!o_tex_sclk) begin
                    sclk_n = 1'b1;
                end else begin
                    // End of a high phase: sample inputs and present the next bit.
                    sclk_n = 1'b0;
                    cnt_n  = cnt - CW'(1);
                    case (state)
                        ST_CMD: begin
                            out0_n = sh[30];
                            sh_n   = {sh[29:0], 1'b0};
                            if (cnt == '0) begin
                                state_n = ST_ADDR;
                                cnt_n   = CW'(23);
                            end
                        end
                        ST_ADDR: begin
                            if (cnt != '0) begin
                                out0_n = sh[30];
                                sh_n   = {sh[29:0], 1'b0};
                            end else begin
                                oeb0_n = 1'b1;
                                out0_n = 1'b0;
                                if (DUMMY_CYCLES > 0) begin
                                    state_n = ST_DUMMY;
                                    cnt_n   = CW'(DUMMY_CYCLES - 1);
                                end else begin
                                    state_n = ST_DATA;
                                    cnt_n   = CW'(DATA_NIBBLES - 1);
                                end
                            end
                        end
                        ST_DUMMY: begin
                            if (cnt == '0) begin
                                state_n = ST_DATA;
                                cnt_n   = CW'(DATA_NIBBLES - 1);
                            end
                        end
                        ST_DATA: begin
                            dsh_n = DW'({dsh, i_tex_in});
                            if (cnt == '0) begin
                                csb_n  = 1'b1;
                                pend_n = 1'b1;
                                // A one-cycle gap is already satisfied by the edge that raises /CS.
                                if (CSB_HIGH_CYCLES <= 1) begin
                                    state_n = ST_IDLE;
                                    ready_n = 1'b1;
                                end else begin
                                    state_n = ST_GAP;
                                    cnt_n   = CW'(CSB_HIGH_CYCLES - 2);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ew_tex_qspi_fetch.sv
// Bench for ew_tex_qspi_fetch: flash model decoding the shifted address, scoreboard of
// accepted fetches, pin protocol monitor, and a second instance with no dummy cycles.
module tb_ew_tex_qspi_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic        rst_a = 1'b1, req_a = 1'b0;
    logic [23:0] addr_a = '0;
    logic        ready_a, busy_a, valid_a, csb_a, sclk_a, oeb0_a, out0_a;
    logic [7:0]  data_a;
    logic [3:0]  tex_in_a = '0;

    logic        rst_b = 1'b1, req_b = 1'b0;
    logic [23:0] addr_b = '0;
    logic        ready_b, busy_b, valid_b, csb_b, sclk_b, oeb0_b, out0_b;
    logic [15:0] data_b;
    logic [3:0]  tex_in_b = '0;

    ew_tex_qspi_fetch #(.CMD(8'h6B), .DUMMY_CYCLES(8), .DATA_NIBBLES(2), .CSB_HIGH_CYCLES(2)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_req(req_a), .i_addr(addr_a),
        .o_ready(ready_a), .o_busy(busy_a), .o_data(data_a), .o_valid(valid_a),
        .o_tex_csb(csb_a), .o_tex_sclk(sclk_a), .o_tex_oeb0(oeb0_a), .o_tex_out0(out0_a),
        .i_tex_in(tex_in_a));

    ew_tex_qspi_fetch #(.CMD(8'h6B), .DUMMY_CYCLES(0), .DATA_NIBBLES(4), .CSB_HIGH_CYCLES(2)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_req(req_b), .i_addr(addr_b),
        .o_ready(ready_b), .o_busy(busy_b), .o_data(data_b), .o_valid(valid_b),
        .o_tex_csb(csb_b), .o_tex_sclk(sclk_b), .o_tex_oeb0(oeb0_b), .o_tex_out0(out0_b),
        .i_tex_in(tex_in_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] flash_fn(input logic [23:0] a);
        case (a)
            24'h012345: return 8'hA7;
            24'h000010: return 8'h3C;
            24'h000020: return 8'hC3;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    typedef struct {
        logic [23:0] addr;
        int          acc;
    } txn_t;
    txn_t sb_a[$];

    int          rise_a = 0, vcnt_a = 0, acc_cnt_a = 0, hi_run_a = 0;
    int          last_gap_a = 0, gap_at_ready_a = 0;
    logic [31:0] stream_a = '0;
    logic        oeb33_a = 1'b0;
    logic        p_sclk_a = 1'b0, p_csb_a = 1'b1, p_out0_a = 1'b0, p_oeb0_a = 1'b1;
    logic        p_valid_a = 1'b0, p_ready_a = 1'b1;

    // Monitor, flash model and scoreboard for instance A, all on the falling edge.
    always @(negedge clk) begin
        txn_t       t;
        int         nib;
        logic [7:0] fw;
        if (csb_a) chk("sclk_while_csb_hi", sclk_a, 1'b0);
        if (out0_a !== p_out0_a || oeb0_a !== p_oeb0_a) chk("pin_change_sclk", sclk_a, 1'b0);
        if (oeb0_a) chk("out0_when_input", out0_a, 1'b0);
        if (valid_a) chk("valid_one_cycle", p_valid_a, 1'b0);
        chk("busy_is_not_ready", busy_a, !ready_a);

        if (csb_a) hi_run_a++;
        else begin
            if (p_csb_a) last_gap_a = hi_run_a;
            hi_run_a = 0;
        end
        if (ready_a && !p_ready_a) gap_at_ready_a = hi_run_a;

        if (csb_a) rise_a = 0;
        else if (sclk_a && !p_sclk_a) begin
            rise_a++;
            if (rise_a <= 32) begin
                stream_a = {stream_a[30:0], out0_a};
                chk("oeb0_cmd_addr", oeb0_a, 1'b0);
            end
            if (rise_a == 33) oeb33_a = oeb0_a;
        end
        nib = rise_a - 41;
        if (!csb_a && sclk_a && nib >= 0 && nib < 2) begin
            fw = flash_fn(stream_a[23:0]) >> (4 * (1 - nib));
            tex_in_a = fw[3:0];
        end else begin
            tex_in_a = 4'($urandom);
        end

        if (valid_a) begin
            vcnt_a++;
            if (sb_a.size() == 0) chk("valid_unexpected_q", sb_a.size(), 1);
            else begin
                t = sb_a.pop_front();
                chk("data", data_a, flash_fn(t.addr));
                chk("stream", stream_a, {8'h6B, t.addr});
                chk("latency", cyc - t.acc, 85);
                chk("oeb0_after_bit31", oeb33_a, 1'b1);
            end
        end
        if (rst_a) sb_a.delete();
        else if (req_a && ready_a) begin
            sb_a.push_back('{addr_a, cyc + 1});
            acc_cnt_a++;
        end

        p_sclk_a  = sclk_a;
        p_csb_a   = csb_a;
        p_out0_a  = out0_a;
        p_oeb0_a  = oeb0_a;
        p_valid_a = valid_a;
        p_ready_a = ready_a;
    end

    int          rise_b = 0;
    logic [31:0] stream_b = '0;
    logic        oeb32_b = 1'b1, oeb33_b = 1'b0, p_sclk_b = 1'b0;
    logic [15:0] fword_b = 16'hBEEF;

    always @(negedge clk) begin
        int          nib;
        logic [15:0] fw;
        if (csb_b) rise_b = 0;
        else if (sclk_b && !p_sclk_b) begin
            rise_b++;
            if (rise_b <= 32) stream_b = {stream_b[30:0], out0_b};
            if (rise_b == 32) oeb32_b = oeb0_b;
            if (rise_b == 33) oeb33_b = oeb0_b;
        end
        nib = rise_b - 33;
        if (!csb_b && sclk_b && nib >= 0 && nib < 4) begin
            fw = fword_b >> (4 * (3 - nib));
            tex_in_b = fw[3:0];
        end else begin
            tex_in_b = 4'($urandom);
        end
        p_sclk_b = sclk_b;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready_a(input int budget);
        for (int i = 0; i < budget && !ready_a; i++) tick();
        chk("ready_timeout", ready_a, 1'b1);
    endtask

    task automatic fetch_a(input logic [23:0] a);
        wait_ready_a(200);
        req_a  = 1'b1;
        addr_a = a;
        tick();
        req_a  = 1'b0;
        addr_a = 24'($urandom);
    endtask

    task automatic drain_a(input int budget);
        for (int i = 0; i < budget && sb_a.size() != 0; i++) tick();
        chk("drain_timeout", sb_a.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, v0, t0;
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk("rst_csb", csb_a, 1'b1);
        chk("rst_sclk", sclk_a, 1'b0);
        chk("rst_oeb0", oeb0_a, 1'b1);
        chk("rst_out0", out0_a, 1'b0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_data", data_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        tick();
        chk("ready_after_rst", ready_a, 1'b1);

        // Single fetch with the reference data.
        fetch_a(24'h012345);
        chk("busy_after_accept", busy_a, 1'b1);
        chk("csb_after_accept", csb_a, 1'b0);
        drain_a(200);
        wait_ready_a(10);
        chk("gap_before_ready", gap_at_ready_a, 2);

        // Request held high across two back-to-back transactions.
        base = acc_cnt_a;
        wait_ready_a(10);
        req_a  = 1'b1;
        addr_a = 24'h000010;
        for (int i = 0; i < 400 && acc_cnt_a < base + 2; i++) begin
            tick();
            if (acc_cnt_a == base + 1) addr_a = 24'h000020;
        end
        req_a = 1'b0;
        chk("held_req_accepts", acc_cnt_a - base, 2);
        drain_a(200);
        chk("csb_gap_back_to_back", last_gap_a, 2);

        // Request during the address phase is ignored.
        v0   = vcnt_a;
        base = acc_cnt_a;
        fetch_a(24'h000001);
        repeat (30) tick();
        chk("ready_low_in_addr", ready_a, 1'b0);
        req_a  = 1'b1;
        addr_a = 24'hFFFFFF;
        tick();
        req_a = 1'b0;
        drain_a(200);
        repeat (100) tick();
        chk("single_accept", acc_cnt_a - base, 1);
        chk("single_valid", vcnt_a - v0, 1);

        // Reset forty cycles into a fetch.
        fetch_a(24'h0ABCDE);
        repeat (39) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("mid_rst_csb", csb_a, 1'b1);
        chk("mid_rst_sclk", sclk_a, 1'b0);
        chk("mid_rst_oeb0", oeb0_a, 1'b1);
        chk("mid_rst_out0", out0_a, 1'b0);
        chk("mid_rst_ready", ready_a, 1'b1);
        chk("mid_rst_data", data_a, 8'h00);
        v0 = vcnt_a;
        repeat (120) tick();
        chk("no_valid_after_rst", vcnt_a - v0, 0);
        chk("data_kept_zero", data_a, 8'h00);
        fetch_a(24'h00BEEF);
        drain_a(200);

        // No dummy cycles, four nibbles.
        req_b  = 1'b1;
        addr_b = 24'h00A5C3;
        tick();
        req_b  = 1'b0;
        addr_b = 24'h0;
        t0 = cyc;
        for (int i = 0; i < 200 && !valid_b; i++) tick();
        chk("b_valid_seen", valid_b, 1'b1);
        chk("b_latency", cyc - t0, 73);
        chk("b_data", data_b, 16'hBEEF);
        chk("b_stream", stream_b, {8'h6B, 24'h00A5C3});
        chk("b_oeb0_bit31", oeb32_b, 1'b0);
        chk("b_oeb0_first_data", oeb33_b, 1'b1);
        tick();
        chk("b_valid_one_cycle", valid_b, 1'b0);
        chk("b_data_held", data_b, 16'hBEEF);

        // Random fetches with occasional resets; the monitor checks protocol throughout.
        for (int k = 0; k < 12; k++) begin
            fetch_a(24'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 90)) tick();
                rst_a = 1'b1;
                tick();
                rst_a = 1'b0;
            end else begin
                drain_a(300);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        drain_a(300);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
